// File: rtl/psinha_pkg.sv
// Shared types and constants for the data-memory path, common to core and arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
package psinha_pkg;

    localparam int DM_AW = 5;
    localparam int DW    = 32;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_HOST = 1'b1
    } psinha_own_t;

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } psinha_arb_st_t;

endpackage

// File: rtl/psinha_rr_pick2.sv
// Two-way round-robin pick: bit 0 = core, bit 1 = host; one-hot grant.
// Latency: combinational.
// Backpressure: none; on contention the side that was not last_own wins.
module psinha_rr_pick2
    import psinha_pkg::*;
(
    input  logic [1:0]  req,
    input  psinha_own_t last_own,
    output logic [1:0]  gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_own == OWN_CORE) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/psinha_dmem_arb.sv
// Core/host arbiter for the single-ported data memory; host lock bursts under PSINHA_DMEM_ARB_LOCK_EN.
// Latency: grant combinational (0 cycles uncontended), read data valid 1 cycle after grant.
// Backpressure: ungranted requester holds its request; the core sees core_stall until granted.
module psinha_dmem_arb
    import psinha_pkg::*;
#(
    parameter int AW    = DM_AW,
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             RN,
    input  logic             c_req,
    input  logic             c_we,
    input  logic [AW-1:0]    c_addr,
    input  logic [DW-1:0]    c_wdata,
    output logic             c_gnt,
    output logic             c_rvalid,
    output logic [DW-1:0]    c_rdata,
    output logic             core_stall,
    input  logic             h_req,
    input  logic             h_we,
    input  logic             h_lock,
    input  logic [AW-1:0]    h_addr,
    input  logic [DW-1:0]    h_wdata,
    output logic             h_gnt,
    output logic             h_rvalid,
    output logic [DW-1:0]    h_rdata,
    output logic             m_en,
    output logic             m_we,
    output logic [AW-1:0]    m_addr,
    output logic [DW-1:0]    m_wdata,
    input  logic [DW-1:0]    m_rdata,
    output logic [CNT_W-1:0] conflict_cnt
);

    psinha_arb_st_t st, st_nxt;
    psinha_own_t    last_own, own_nxt;
    psinha_own_t    rd_own;
    logic           rd_vld;
    logic [1:0]     rr_gnt;

    psinha_rr_pick2 u_pick (
        .req      ({h_req, c_req}),
        .last_own (last_own),
        .gnt      (rr_gnt)
    );

    always_comb begin
        st_nxt  = st;
        own_nxt = last_own;
        c_gnt   = 1'b0;
        h_gnt   = 1'b0;
        if (!RN) begin
`ifdef PSINHA_DMEM_ARB_LOCK_EN
            // A lock-release cycle falls through to normal arbitration.
            if (st == ST_LOCKED && h_lock) begin
                h_gnt = h_req;
            end else begin
                c_gnt  = rr_gnt[0];
                h_gnt  = rr_gnt[1];
                st_nxt = (rr_gnt[1] && h_lock) ? ST_LOCKED : ST_ARB;
            end
`else
            c_gnt = rr_gnt[0];
            h_gnt = rr_gnt[1];
`endif
            if (c_gnt)
                own_nxt = OWN_CORE;
            else if (h_gnt)
                own_nxt = OWN_HOST;
        end
    end

`ifndef PSINHA_DMEM_ARB_LOCK_EN
    logic unused_h_lock;
    assign unused_h_lock = h_lock;
`endif

    assign m_en       = c_gnt | h_gnt;
    assign m_we       = (c_gnt & c_we) | (h_gnt & h_we);
    assign m_addr     = h_gnt ? h_addr  : c_addr;
    assign m_wdata    = h_gnt ? h_wdata : c_wdata;
    assign core_stall = c_req & ~c_gnt & ~RN;

    // Gating with RN drops a read return that lands on a reset cycle.
    assign c_rvalid = rd_vld & (rd_own == OWN_CORE) & ~RN;
    assign h_rvalid = rd_vld & (rd_own == OWN_HOST) & ~RN;
    assign c_rdata  = m_rdata;
    assign h_rdata  = m_rdata;

    always_ff @(posedge clk) begin
        if (RN) begin
            st           <= ST_ARB;
            last_own     <= OWN_HOST;
            rd_vld       <= 1'b0;
            rd_own       <= OWN_CORE;
            conflict_cnt <= '0;
        end else begin
            st       <= st_nxt;
            last_own <= own_nxt;
            rd_vld   <= m_en & ~m_we;
            rd_own   <= h_gnt ? OWN_HOST : OWN_CORE;
            if (c_req && h_req && (conflict_cnt != {CNT_W{1'b1}}))
                conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

endmodule
